// File: rtl/display7s_mux.sv
// Scans four BCD digits onto a multiplexed 7-segment display and blinks the colon. Outputs are registered.
// Latency: one clock from state to pins. Backpressure: none; the inputs are sampled once per frame.
module display7s_mux #(
    parameter int DIV            = 50000,
    parameter int GUARD          = 2,
    parameter int BLINK_FRAMES   = 125,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int BLANK_LZ       = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] us,
    input  logic [3:0] ds,
    input  logic [3:0] um,
    input  logic [3:0] dm,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int CW = $clog2(DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] GUARD_END  = CW'(GUARD);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [3:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] s;
        case (bcd)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    us_q, us_d, ds_q, ds_d, um_q, um_d, dm_q, dm_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          phase_q, phase_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    an_q, an_d;

    logic       tick;
    logic       wrap;
    logic       blank;
    logic [3:0] digit;
    logic [6:0] seg_raw;
    logic [3:0] an_raw;
    logic       dp_raw;

    always_comb begin
        tick    = (cnt_q == CNT_LAST);
        wrap    = tick && (idx_q == 2'd3);
        cnt_d   = tick ? '0 : cnt_q + CW'(1);
        idx_d   = tick ? idx_q + 2'd1 : idx_q;

        // The whole digit set is captured at the frame boundary so a frame never mixes old and new digits.
        us_d    = wrap ? us : us_q;
        ds_d    = wrap ? ds : ds_q;
        um_d    = wrap ? um : um_q;
        dm_d    = wrap ? dm : dm_q;

        frame_d = frame_q;
        phase_d = phase_q;
        if (wrap) begin
            if (frame_q == FRAME_LAST) begin
                frame_d = '0;
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + FW'(1);
            end
        end

        case (idx_d)
            2'd0:    digit = us_d;
            2'd1:    digit = ds_d;
            2'd2:    digit = um_d;
            default: digit = dm_d;
        endcase

        blank   = (BLANK_LZ != 0) && (idx_d == 2'd3) && (dm_d == 4'd0);
        seg_raw = blank ? 7'h00 : bcd_to_seg(digit);
        // Anodes stay dark for the first GUARD cycles so the previous digit's segments cannot ghost.
        an_raw  = ((cnt_d >= GUARD_END) && !blank) ? (4'b0001 << idx_d) : 4'b0000;
        dp_raw  = (idx_d == 2'd2) && phase_d;

        seg_d   = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
        dp_d    = (SEG_ACTIVE_LOW != 0) ? ~dp_raw  : dp_raw;
        an_d    = (AN_ACTIVE_LOW  != 0) ? ~an_raw  : an_raw;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            us_q    <= '0;
            ds_q    <= '0;
            um_q    <= '0;
            dm_q    <= '0;
            frame_q <= '0;
            phase_q <= 1'b1;
            seg_q   <= SEG_OFF;
            dp_q    <= DP_OFF;
            an_q    <= AN_OFF;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            us_q    <= us_d;
            ds_q    <= ds_d;
            um_q    <= um_d;
            dm_q    <= dm_d;
            frame_q <= frame_d;
            phase_q <= phase_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule
